// File: rtl/matrix_mac_engine.sv
// Handshaked M_SIZE x M_SIZE signed matrix multiply-accumulate engine (C <= A*B + C).
// One inner-product step per cycle; wide accumulators persist across jobs.
module matrix_mac_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int M_SIZE     = 4,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic                                         in_clear,
    input  logic [M_SIZE-1:0][M_SIZE-1:0][DATA_WIDTH-1:0] in_a,
    input  logic [M_SIZE-1:0][M_SIZE-1:0][DATA_WIDTH-1:0] in_b,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [M_SIZE-1:0][M_SIZE-1:0][DATA_WIDTH-1:0] out_result,
    output logic                                         out_overflow
);

    localparam int KW = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
    localparam int TW = ACC_WIDTH - DATA_WIDTH + 1;

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
        $error("matrix_mac_engine: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end
    if (M_SIZE < 2) begin : g_m_size_check
        $error("matrix_mac_engine: M_SIZE must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [M_SIZE-1:0][M_SIZE-1:0][DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [M_SIZE-1:0][M_SIZE-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;
    logic accept_s, mac_en_s;
    logic signed [2*DATA_WIDTH-1:0] prod_s [M_SIZE][M_SIZE];
    logic signed [ACC_WIDTH-1:0]    ext_s  [M_SIZE][M_SIZE];

    // A value fits when every bit above the DATA_WIDTH sign bit matches that sign bit.
    function automatic logic fits_f(input logic [ACC_WIDTH-1:0] v);
        logic [TW-1:0] top;
        top = v[ACC_WIDTH-1:DATA_WIDTH-1];
        return (top == {TW{1'b0}}) || (top == {TW{1'b1}});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] conv_f(input logic [ACC_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (fits_f(v) || !SATURATE) begin
            r = v[DATA_WIDTH-1:0];
        end else if (v[ACC_WIDTH-1]) begin
            r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (k_q == KW'(M_SIZE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready is held low while reset is asserted
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept_s  = 1'b0;
        mac_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = reset;
                accept_s = in_valid;
            end
            ST_MAC:  mac_en_s  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // One signed product per accumulator for the current k-step, sign-extended
    always_comb begin
        for (int i = 0; i < M_SIZE; i++) begin
            for (int j = 0; j < M_SIZE; j++) begin
                prod_s[i][j] = $signed(a_q[i][k_q]) * $signed(b_q[k_q][j]);
                ext_s[i][j]  = prod_s[i][j];
            end
        end
    end

    // Datapath next state: operand capture on accept, accumulate during MAC
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        k_d   = k_q;
        acc_d = acc_q;
        if (accept_s) begin
            a_d = in_a;
            b_d = in_b;
            k_d = {KW{1'b0}};
            if (in_clear) begin
                acc_d = {(M_SIZE*M_SIZE*ACC_WIDTH){1'b0}};
            end else begin
                acc_d = acc_q;
            end
        end else if (mac_en_s) begin
            k_d = k_q + KW'(1);
            for (int i = 0; i < M_SIZE; i++) begin
                for (int j = 0; j < M_SIZE; j++) begin
                    acc_d[i][j] = acc_q[i][j] + ext_s[i][j];
                end
            end
        end else begin
            k_d = k_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q   <= {(M_SIZE*M_SIZE*DATA_WIDTH){1'b0}};
            b_q   <= {(M_SIZE*M_SIZE*DATA_WIDTH){1'b0}};
            k_q   <= {KW{1'b0}};
            acc_q <= {(M_SIZE*M_SIZE*ACC_WIDTH){1'b0}};
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            k_q   <= k_d;
            acc_q <= acc_d;
        end
    end

    // Result conversion straight from the accumulators
    always_comb begin
        out_overflow = 1'b0;
        for (int i = 0; i < M_SIZE; i++) begin
            for (int j = 0; j < M_SIZE; j++) begin
                out_result[i][j] = conv_f(acc_q[i][j]);
                out_overflow     = out_overflow | ~fits_f(acc_q[i][j]);
            end
        end
    end

endmodule

// File: doc/matrix_mac_engine.md
# matrix_mac_engine

Parametrised, handshaked matrix multiply-accumulate engine computing C ← A·B + C over M_SIZE×M_SIZE signed operand matrices. It time-multiplexes the inner-product dimension: one k-step per cycle across all M_SIZE² accumulators. It keeps wide internal accumulators that persist across jobs, and presents a saturated or truncated DATA_WIDTH result through a valid/ready output port. It sits between the operand fetch stage and the result writeback stage of the mmac datapath.

## Interface
- DATA_WIDTH, 16, signed element width of A, B and result.
- ACC_WIDTH, 40, signed internal accumulator width; must be ≥ 2·DATA_WIDTH (elaboration-time assertion).
- M_SIZE, 4, matrix dimension (≥ 2).
- SATURATE, 1, 1 = clamp result to the signed DATA_WIDTH range; 0 = keep the low DATA_WIDTH bits.
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand job offered.
- in_ready  output  1  engine can accept a job.
- in_clear  input  1  sampled with the job; 1 = start accumulators from zero.
- in_a  input  [M_SIZE][M_SIZE][DATA_WIDTH]  matrix A, signed, indexed [row][col].
- in_b  input  [M_SIZE][M_SIZE][DATA_WIDTH]  matrix B, signed.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_result  output  [M_SIZE][M_SIZE][DATA_WIDTH]  converted accumulator contents.
- out_overflow  output  1  at least one element of out_result was clamped (SATURATE=1) or truncated lossily (SATURATE=0).

## Operation
- FSM states: IDLE, MAC, DONE. Reset state is IDLE.
- in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
- IDLE:
  - When in_valid is high, latch in_a and in_b into internal operand registers and clear k to 0.
  - If in_clear = 1, zero all accumulators; otherwise leave them untouched.
  - Go to MAC.
- MAC:
  - Each cycle, acc[i][j] += sext(A[i][k]·B[k][j]) for all i, j in parallel, using M_SIZE² signed multipliers.
  - Increment k each cycle.
  - On the cycle with k = M_SIZE−1, perform the update and go to DONE.
- DONE:
  - Hold the accumulators.
  - On out_valid && out_ready, go to IDLE.
- Arithmetic:
  - Products are full 2·DATA_WIDTH signed values, sign-extended to ACC_WIDTH.
  - Accumulator addition wraps modulo 2^ACC_WIDTH, with no internal saturation.
- Output conversion is combinational from the accumulators:
  - SATURATE=1: values > 2^(DATA_WIDTH−1)−1 clamp to max; values < −2^(DATA_WIDTH−1) clamp to min.
  - SATURATE=0: out_result takes the low DATA_WIDTH bits.
  - out_overflow is the OR across all elements of "value not representable in DATA_WIDTH signed".
- The accumulators persist after the DONE handshake. The next job without in_clear accumulates on top of them.
- in_valid is ignored outside IDLE. Operand inputs may change freely once a job is accepted.

## Timing
- Job accepted at edge T (IDLE, in_valid = 1). MAC occupies the cycles after edges T+1 … T+M_SIZE, and out_valid rises after edge T+M_SIZE.
- Latency from acceptance to out_valid: M_SIZE cycles.
- If out_ready is already high when DONE is entered, the handshake completes at edge T+M_SIZE+1 and the engine is in IDLE. The next accept occurs at T+M_SIZE+2 at the earliest, so minimum initiation interval = M_SIZE+2 cycles.
- Backpressure: while out_ready = 0 in DONE, out_valid, out_result and out_overflow stay stable, and in_ready stays 0.
- Reset asserted (async), at any time including mid-MAC:
  - Immediately: state = IDLE, k = 0, accumulators = 0, operand registers = 0.
  - Outputs while reset is low: out_valid = 0, in_ready = 0, out_result = 0, out_overflow = 0.
  - The in-flight job is discarded.
  - in_ready rises in the first cycle after reset deasserts.
- in_clear together with in_valid while not IDLE: no effect.

## Test plan
- Basic product (M_SIZE=2, DATA_WIDTH=8, ACC_WIDTH=20, SATURATE=1):
  - Stimulus: A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_clear=1, out_ready=1.
  - Response: out_result=[[19,22],[43,50]], out_overflow=0, out_valid exactly 2 cycles after accept, in_ready back to 1 after the handshake.
- Accumulation and clear:
  - Stimulus: repeat the same job with in_clear=0.
  - Response: [[38,44],[86,100]].
  - Then the same job with in_clear=1 → [[19,22],[43,50]] again.
- Saturation:
  - Stimulus: A and B all 127, in_clear=1.
  - Response with SATURATE=1: every element 32258 → 127, out_overflow=1.
  - Response with SATURATE=0: every element 2 (32258 mod 256), out_overflow=1.
  - Stimulus: A all −128, B all 127 (SATURATE=1) → every element −128, out_overflow=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Response: out_valid and out_result constant, in_ready=0, and the new operands are not accepted until the handshake completes.
- Reset mid-MAC (M_SIZE=4):
  - Stimulus: assert reset one cycle after accept.
  - Response: out_valid=0 and out_result=0 immediately; in_ready=1 in the first cycle after release.
  - Then a job with in_clear=0 yields the pure A·B result (accumulators were zeroed by reset).
